mem_access_arbiter: RTL

- Sequences and shares the single-port 16x8 data memory behind the MBR between two requesters: port 0 (instruction fetch) and port 1 (execute/load-store).
- Arbitrates round-robin, latches the winner's command and drives the memory address, write-data and write-enable for exactly one issue cycle.
- Waits out the memory read latency, captures read data into a per-port register and pulses a per-port completion strobe.

---
 rtl/mem_access_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mem_access_arbiter.sv
// Round-robin sequencer sharing one single-port data memory between an
// instruction-fetch port (0) and a load/store port (1).
module mem_access_arbiter #(
  parameter int AW     = 4,
  parameter int DW     = 8,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  output logic          done0,
  output logic [DW-1:0] rdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  output logic          done1,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam int CW = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t          state_r, state_s;
  logic            last_gnt_r, last_gnt_s;
  logic            win_r, win_s;
  logic            cmd_we_r, cmd_we_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            mem_we_r, mem_we_s;
  logic [AW-1:0]   mem_addr_r, mem_addr_s;
  logic [DW-1:0]   mem_wdata_r, mem_wdata_s;
  logic            gnt0_r, gnt0_s, gnt1_r, gnt1_s;
  logic            done0_r, done0_s, done1_r, done1_s;
  logic [DW-1:0]   rdata0_r, rdata0_s, rdata1_r, rdata1_s;
  logic            busy_r, busy_s;
  logic            pick_s;

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_s     = state_r;
    last_gnt_s  = last_gnt_r;
    win_s       = win_r;
    cmd_we_s    = cmd_we_r;
    cnt_s       = cnt_r;
    mem_we_s    = 1'b0;
    mem_addr_s  = mem_addr_r;
    mem_wdata_s = mem_wdata_r;
    gnt0_s      = 1'b0;
    gnt1_s      = 1'b0;
    done0_s     = 1'b0;
    done1_s     = 1'b0;
    rdata0_s    = rdata0_r;
    rdata1_s    = rdata1_r;
    pick_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time goes next.
          pick_s      = (req0 && req1) ? ~last_gnt_r : req1;
          win_s       = pick_s;
          last_gnt_s  = pick_s;
          cmd_we_s    = pick_s ? we1 : we0;
          mem_we_s    = pick_s ? we1 : we0;
          mem_addr_s  = pick_s ? addr1 : addr0;
          mem_wdata_s = pick_s ? wdata1 : wdata0;
          gnt0_s      = ~pick_s;
          gnt1_s      = pick_s;
          state_s     = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (cmd_we_r) begin
          done0_s = ~win_r;
          done1_s = win_r;
          state_s = RESP;
        end else begin
          cnt_s   = CW'(RD_LAT);
          state_s = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r == 2'd1) begin
          if (win_r) begin
            rdata1_s = mem_rdata;
          end else begin
            rdata0_s = mem_rdata;
          end
          done0_s = ~win_r;
          done1_s = win_r;
          cnt_s   = 2'd0;
          state_s = RESP;
        end else begin
          cnt_s = cnt_r - 2'd1;
        end
      end
      RESP: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      last_gnt_r  <= 1'b1;
      win_r       <= 1'b0;
      cmd_we_r    <= 1'b0;
      cnt_r       <= 2'd0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      gnt0_r      <= 1'b0;
      gnt1_r      <= 1'b0;
      done0_r     <= 1'b0;
      done1_r     <= 1'b0;
      rdata0_r    <= '0;
      rdata1_r    <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      last_gnt_r  <= last_gnt_s;
      win_r       <= win_s;
      cmd_we_r    <= cmd_we_s;
      cnt_r       <= cnt_s;
      mem_we_r    <= mem_we_s;
      mem_addr_r  <= mem_addr_s;
      mem_wdata_r <= mem_wdata_s;
      gnt0_r      <= gnt0_s;
      gnt1_r      <= gnt1_s;
      done0_r     <= done0_s;
      done1_r     <= done1_s;
      rdata0_r    <= rdata0_s;
      rdata1_r    <= rdata1_s;
      busy_r      <= busy_s;
    end
  end

  assign gnt0      = gnt0_r;
  assign gnt1      = gnt1_r;
  assign done0     = done0_r;
  assign done1     = done1_r;
  assign rdata0    = rdata0_r;
  assign rdata1    = rdata1_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_we    = mem_we_r;
  assign busy      = busy_r;

endmodule
